kem_cmd_sequencer: RTL

//  Host-side initiator for the ML-KEM top-level controller. Queues host commands (keygen/encap/decap),

---
 rtl/kem_cmd_sequencer_pkg.sv | 23 ++
 rtl/kem_cmd_sequencer_fifo.sv | 54 +++++
 rtl/kem_cmd_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/kem_cmd_sequencer_pkg.sv
// kem_cmd_sequencer_pkg: shared ML-KEM mode, response status and sequencer state types
// Contents: kem_mode_t (one-hot keygen/encap/decap), kem_rsp_status_t with KEM_RSP_* codes,
// state_kem_seq_t FSM encodings, and is_onehot() for mode validation.
package kem_cmd_sequencer_pkg;
    typedef logic [2:0] kem_mode_t;
    localparam kem_mode_t KEM_MODE_NONE   = 3'b000;
    localparam kem_mode_t KEM_MODE_KEYGEN = 3'b100;
    localparam kem_mode_t KEM_MODE_ENCAP  = 3'b010;
    localparam kem_mode_t KEM_MODE_DECAP  = 3'b001;
    typedef logic [1:0] kem_rsp_status_t;
    localparam kem_rsp_status_t KEM_RSP_OK      = 2'd0;
    localparam kem_rsp_status_t KEM_RSP_ILLEGAL = 2'd1;
    localparam kem_rsp_status_t KEM_RSP_TIMEOUT = 2'd2;
    typedef logic [2:0] state_kem_seq_t;
    localparam state_kem_seq_t ST_IDLE      = 3'd0;
    localparam state_kem_seq_t ST_RELEASE   = 3'd1;
    localparam state_kem_seq_t ST_ISSUE     = 3'd2;
    localparam state_kem_seq_t ST_WAIT_DONE = 3'd3;
    localparam state_kem_seq_t ST_RESP      = 3'd4;
    function automatic logic is_onehot(input kem_mode_t m);
        return m == KEM_MODE_KEYGEN || m == KEM_MODE_ENCAP || m == KEM_MODE_DECAP;
    endfunction
endpackage

// File: rtl/kem_cmd_sequencer_fifo.sv
// kem_cmd_fifo: synchronous command FIFO with registered full/empty flags
// Ports: clk_i, rst_n_i (async active-low, flushes), push_i/wdata_i (ignored when full),
// pop_i (ignored when empty), rdata_o (head entry), full_o, empty_o.
module kem_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 7
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic full_q, full_d, empty_q, empty_d, push, pop;
    always_comb begin
        push = push_i & ~full_q;
        pop = pop_i & ~empty_q;
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        full_d = count_d == (AW+1)'(DEPTH);
        empty_d = count_d == '0;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            full_q <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            full_q <= full_d;
            empty_q <= empty_d;
        end
    end
    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/kem_cmd_sequencer.sv
// kem_cmd_sequencer: host-side command queue and run/done sequencer for the ML-KEM controller
// Ports: clk_i, rst_n_i (async active-low); host cmd_valid_i/cmd_ready_o/cmd_mode_i/cmd_id_i;
// host rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_status_o; controller run_o/mode_o/done_i/abort_o;
// status key_valid_o, busy_o.
// Option: define KEM_TIMEOUT_EN to enable the WAIT_DONE watchdog (TIMEOUT_CYCLES) and abort_o.
module kem_cmd_sequencer
    import kem_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [2:0]      cmd_mode_i,
    input  logic [ID_W-1:0] cmd_id_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [ID_W-1:0] rsp_id_o,
    output logic [1:0]      rsp_status_o,
    output logic            run_o,
    output logic [2:0]      mode_o,
    input  logic [2:0]      done_i,
    output logic            key_valid_o,
    output logic            busy_o,
    output logic            abort_o
);
    state_kem_seq_t state_q, state_d;
    kem_mode_t mode_q, mode_d, head_mode;
    kem_rsp_status_t status_q, status_d;
    logic [ID_W-1:0] id_q, id_d, head_id;
    logic key_valid_q, key_valid_d, fifo_full, fifo_empty, fifo_pop, done_hit, timeout_hit;
    logic [ID_W+2:0] fifo_rdata;
    kem_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(ID_W + 3)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (cmd_valid_i),
        .wdata_i ({cmd_id_i, cmd_mode_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
    assign head_mode = fifo_rdata[2:0];
    assign head_id = fifo_rdata[ID_W+2:3];
    assign done_hit = |(done_i & mode_q);
`ifdef KEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign timeout_hit = cnt_q == CW'(TIMEOUT_CYCLES);
    // The only way into WAIT_DONE is through ISSUE, so clearing there restarts the watchdog.
    always_comb cnt_d = state_q == ST_ISSUE ? '0 : (state_q == ST_WAIT_DONE && !timeout_hit) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        id_d = id_q;
        mode_d = mode_q;
        status_d = status_q;
        key_valid_d = key_valid_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                fifo_pop = 1'b1;
                id_d = head_id;
                mode_d = head_mode;
                status_d = KEM_RSP_OK;
                if (!is_onehot(head_mode) || (head_mode == KEM_MODE_DECAP && !key_valid_q)) begin
                    status_d = KEM_RSP_ILLEGAL;
                    state_d = ST_RESP;
                end else begin
                    // A held keygen result must be dropped before the controller accepts another op.
                    state_d = (head_mode != KEM_MODE_DECAP && key_valid_q) ? ST_RELEASE : ST_ISSUE;
                end
            end
            ST_RELEASE: begin
                key_valid_d = 1'b0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (done_hit) begin
                state_d = ST_RESP;
                status_d = KEM_RSP_OK;
                key_valid_d = mode_q == KEM_MODE_KEYGEN ? 1'b1 : mode_q == KEM_MODE_DECAP ? 1'b0 : key_valid_q;
            end else if (timeout_hit) begin
                state_d = ST_RESP;
                status_d = KEM_RSP_TIMEOUT;
                key_valid_d = 1'b0;
            end
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            id_q <= '0;
            mode_q <= KEM_MODE_NONE;
            status_q <= KEM_RSP_OK;
            key_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q <= id_d;
            mode_q <= mode_d;
            status_q <= status_d;
            key_valid_q <= key_valid_d;
        end
    end
    assign cmd_ready_o = ~fifo_full;
    assign run_o = state_q == ST_RELEASE || state_q == ST_ISSUE;
    assign mode_o = (state_q == ST_ISSUE || state_q == ST_WAIT_DONE) ? mode_q : KEM_MODE_NONE;
    assign rsp_valid_o = state_q == ST_RESP;
    assign rsp_id_o = id_q;
    assign rsp_status_o = status_q;
    assign key_valid_o = key_valid_q;
    assign busy_o = state_q != ST_IDLE;
    assign abort_o = state_q == ST_WAIT_DONE && timeout_hit && !done_hit;
endmodule
